// File: rtl/res_bcd_conv.sv
// Sequential binary-to-BCD converter (double dabble) for an ALU result.
// Takes one bit per clock and exposes the BCD value with valid/ack handshaking.
module res_bcd_conv #(
  parameter int width  = 8,
  parameter int digits = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic [2*width-1:0]    res_i,
  input  logic                  start_i,
  output logic                  ready_o,
  output logic [4*digits-1:0]   bcd_o,
  output logic                  valid_o,
  output logic                  ovf_o,
  input  logic                  ack_i
);

  localparam int BW = 2 * width;
  localparam int DW = 4 * digits;
  localparam int CW = $clog2(BW + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(BW - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [BW-1:0] bin_q, bin_d;
  logic [DW-1:0] acc_q, acc_d;
  logic [DW-1:0] bcd_q, bcd_d;
  logic          ovf_q, ovf_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [DW-1:0] adj;
  logic [DW-1:0] acc_sh;
  logic [BW-1:0] bin_sh;
  logic          shift_out;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case leaves a latch.
    state_d = state_q;
    bin_d   = bin_q;
    acc_d   = acc_q;
    bcd_d   = bcd_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;

    // Pre-correct each digit so the following doubling carries in decimal.
    adj = acc_q;
    for (int i = 0; i < digits; i++) begin
      if (acc_q[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
    end
    {shift_out, acc_sh, bin_sh} = {adj, bin_q, 1'b0};

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          bin_d   = res_i;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        bin_d = bin_sh;
        acc_d = acc_sh;
        ovf_d = ovf_q | shift_out;
        cnt_d = cnt_q + CW'(1);
        // Only the final shift publishes the result, so bcd_o never shows partial values.
        if (cnt_q == LAST_CNT) begin
          bcd_d   = acc_sh;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (ack_i) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q <= S_IDLE;
      bin_q   <= '0;
      acc_q   <= '0;
      bcd_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      acc_q   <= acc_d;
      bcd_q   <= bcd_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign valid_o = (state_q == S_DONE);
  assign bcd_o   = bcd_q;
  assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_res_bcd_conv.sv
// Bench for res_bcd_conv: a 5-digit and a 4-digit instance share stimulus and
// are compared against a decimal-arithmetic reference model.
module tb_res_bcd_conv;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        ack   = 1'b0;
  logic [15:0] res   = '0;

  logic        ready5, valid5, ovf5;
  logic [19:0] bcd5;
  logic        ready4, valid4, ovf4;
  logic [15:0] bcd4;

  int checks   = 0;
  int failures = 0;

  logic [19:0] prev5 = '0;
  logic [15:0] prev4 = '0;

  res_bcd_conv #(.width(8), .digits(5)) dut5 (
    .clk_i(clk), .rst_n_i(rst_n), .res_i(res), .start_i(start),
    .ready_o(ready5), .bcd_o(bcd5), .valid_o(valid5), .ovf_o(ovf5), .ack_i(ack)
  );

  res_bcd_conv #(.width(8), .digits(4)) dut4 (
    .clk_i(clk), .rst_n_i(rst_n), .res_i(res), .start_i(start),
    .ready_o(ready4), .bcd_o(bcd4), .valid_o(valid4), .ovf_o(ovf4), .ack_i(ack)
  );

  // Decimal digits of v, lowest nd digits, least significant in [3:0].
  function automatic logic [19:0] ref_bcd(int unsigned v, int nd);
    logic [19:0] r;
    r = '0;
    for (int i = 0; i < nd; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic ref_ovf(int unsigned v, int nd);
    int unsigned lim;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    return (v >= lim);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_result(string tag, int unsigned v);
    logic [19:0] e5;
    logic [19:0] e4;
    e5 = ref_bcd(v, 5);
    e4 = ref_bcd(v, 4);
    check({tag, "_valid5"}, 32'(valid5), 32'(1'b1));
    check({tag, "_bcd5"},   32'(bcd5),   32'(e5));
    check({tag, "_ovf5"},   32'(ovf5),   32'(ref_ovf(v, 5)));
    check({tag, "_ready5"}, 32'(ready5), 32'(1'b0));
    check({tag, "_valid4"}, 32'(valid4), 32'(1'b1));
    check({tag, "_bcd4"},   32'(bcd4),   32'(e4[15:0]));
    check({tag, "_ovf4"},   32'(ovf4),   32'(ref_ovf(v, 4)));
    prev5 = e5;
    prev4 = e4[15:0];
  endtask

  task automatic ack_pulse(string tag);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check({tag, "_idle_ready"}, 32'(ready5), 32'(1'b1));
    check({tag, "_idle_valid"}, 32'(valid5), 32'(1'b0));
    check({tag, "_hold_bcd5"},  32'(bcd5),   32'(prev5));
    check({tag, "_hold_bcd4"},  32'(bcd4),   32'(prev4));
  endtask

  // One conversion; noisy toggles start/ack during the shift phase, which must be ignored.
  task automatic run_conv(string tag, int unsigned v, bit noisy, bit do_ack);
    check({tag, "_ready_before"}, 32'(ready5), 32'(1'b1));
    res   = 16'(v);
    start = 1'b1;
    step();
    start = 1'b0;
    res   = 16'($urandom);
    check({tag, "_busy"}, 32'(ready5), 32'(1'b0));
    for (int i = 1; i <= 16; i++) begin
      if (noisy) begin
        start = 1'($urandom % 2);
        ack   = 1'($urandom % 2);
      end
      step();
      if (i == 15) begin
        check({tag, "_not_yet_valid"}, 32'(valid5), 32'(1'b0));
        check({tag, "_old_bcd5"},      32'(bcd5),   32'(prev5));
        check({tag, "_old_bcd4"},      32'(bcd4),   32'(prev4));
      end
    end
    start = 1'b0;
    ack   = 1'b0;
    check_result(tag, v);
    if (do_ack) ack_pulse(tag);
  endtask

  initial begin
    int ready_seen;
    int valid_seen;

    // Reset state.
    rst_n = 1'b0;
    step();
    step();
    check("rst_ready", 32'(ready5), 32'(1'b1));
    check("rst_valid", 32'(valid5), 32'(1'b0));
    check("rst_bcd5",  32'(bcd5),   32'(0));
    check("rst_ovf5",  32'(ovf5),   32'(1'b0));
    check("rst_bcd4",  32'(bcd4),   32'(0));
    rst_n = 1'b1;

    // Basic values.
    run_conv("v20",    20,    1'b0, 1'b1);
    run_conv("v65535", 65535, 1'b0, 1'b1);
    run_conv("v0",     0,     1'b0, 1'b1);

    // start held high with no ack: a single conversion, DONE holds.
    check("hold_ready_before", 32'(ready5), 32'(1'b1));
    res   = 16'd9999;
    start = 1'b1;
    ready_seen = 0;
    valid_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (ready5) ready_seen++;
      if (valid5) valid_seen++;
    end
    check("hold_ready_seen", 32'(ready_seen), 32'(0));
    check("hold_valid_seen", 32'(valid_seen), 32'(14));
    start = 1'b0;
    check_result("hold", 9999);
    ack_pulse("hold");

    // Reset at edge k+7 aborts the conversion.
    res   = 16'd1234;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (6) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("abort_valid", 32'(valid5), 32'(1'b0));
    check("abort_bcd5",  32'(bcd5),   32'(0));
    check("abort_ready", 32'(ready5), 32'(1'b1));
    check("abort_bcd4",  32'(bcd4),   32'(0));
    prev5 = '0;
    prev4 = '0;
    run_conv("v6", 6, 1'b0, 1'b1);

    // Digit-count boundary for the 4-digit instance.
    run_conv("v10000", 10000, 1'b0, 1'b1);
    run_conv("v9999",  9999,  1'b0, 1'b1);

    // ack and start together in DONE: leave DONE, start accepted on the next edge.
    run_conv("v77", 77, 1'b0, 1'b0);
    ack   = 1'b1;
    start = 1'b1;
    res   = 16'd321;
    step();
    ack = 1'b0;
    check("both_ready", 32'(ready5), 32'(1'b1));
    check("both_valid", 32'(valid5), 32'(1'b0));
    step();
    start = 1'b0;
    check("both_next_accept", 32'(ready5), 32'(1'b0));
    repeat (16) step();
    check_result("v321", 321);
    ack_pulse("v321");

    // Random values with start/ack noise during the shift phase.
    for (int n = 0; n < 24; n++) begin
      run_conv("rand", $urandom_range(0, 65535), 1'b1, 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
